// File: rtl/mac_pkg.sv
// Shared definitions for the iterative multiply-accumulate unit: state codes,
// default geometry, the mode-bit bundle and the early-termination chunk counter.
package mac_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP  = 8;
  localparam int MAX_WIDTH = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic acc_en;
    logic long_en;
    logic signed_en;
  } mode_t;

  // Smallest n in 1..K whose multiplier bits above n*step carry no information:
  // all zero when unsigned, all copies of bit n*step-1 when signed.
  function automatic int chunk_count(input logic [MAX_WIDTH-1:0] b, input int width,
                                     input int step, input logic sgn);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] upper;
    logic                 ok;
    int                   k;
    int                   cnt;
    mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    k    = width / step;
    cnt  = k;
    for (int n = MAX_WIDTH; n >= 1; n--) begin
      if (n < k) begin
        if (sgn) begin
          upper = (b & mask) >> (n * step - 1);
          ok    = (upper == '0) || (upper == (mask >> (n * step - 1)));
        end else begin
          ok = (((b & mask) >> (n * step)) == '0);
        end
        if (ok) cnt = n;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mac_step.sv
// One partial-product step: adds ext(a) * chunk, shifted to the chunk's
// position, into the 2W-bit running sum (modulo 2^(2W)).
module mac_step
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP,
  parameter int KW    = 3
) (
  input  logic [2*WIDTH-1:0] sum,
  input  logic [2*WIDTH-1:0] a_ext,
  input  logic [STEP-1:0]    chunk,
  input  logic               chunk_signed,
  input  logic [KW-1:0]      idx,
  output logic [2*WIDTH-1:0] sum_next
);

  logic [2*WIDTH-1:0] chunk_ext;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    chunk_ext = {{(2*WIDTH-STEP){chunk_signed & chunk[STEP-1]}}, chunk};
    prod      = a_ext * chunk_ext;
    sum_next  = sum + (prod << (STEP * idx));
  end

endmodule

// File: rtl/mac_iter.sv
// Iterative multiply-accumulate (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL), STEP multiplier
// bits per cycle with early termination on redundant upper multiplier bits.
module mac_iter
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [WIDTH-1:0]                op_a,
  input  logic [WIDTH-1:0]                op_b,
  input  logic [WIDTH-1:0]                acc_hi,
  input  logic [WIDTH-1:0]                acc_lo,
  input  logic                            acc_en,
  input  logic                            long_en,
  input  logic                            signed_en,
  output logic                            busy,
  output logic                            done,
  output logic [WIDTH-1:0]                result_hi,
  output logic [WIDTH-1:0]                result_lo,
  output logic                            flag_n,
  output logic                            flag_z,
  output logic [$clog2(WIDTH/STEP):0]     cycles,
  output logic [1:0]                      dbg_state
);

  localparam int K  = WIDTH / STEP;
  localparam int KW = $clog2(K) + 1;
  localparam int W2 = 2 * WIDTH;

  // Handshake: start is accepted on a rising edge only while busy=0 (IDLE or
  // DONE); done is a one-cycle pulse and the result registers hold until the next one.
  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [KW-1:0]    n_q;
  logic [WIDTH-1:0] b_sh;
  logic [W2-1:0]    a_ext_q;
  logic [W2-1:0]    sum_q;
  logic             long_q;
  logic             sgn_q;

  mode_t         op_mode;
  logic          op_sgn;
  logic [KW-1:0] n_start;
  logic [W2-1:0] a_ext_start;
  logic [W2-1:0] acc_start;
  logic          last;
  logic [W2-1:0] sum_next;

  always_comb begin
    op_mode     = '{acc_en: acc_en, long_en: long_en, signed_en: signed_en};
    op_sgn      = op_mode.signed_en & op_mode.long_en;
    n_start     = KW'(chunk_count(MAX_WIDTH'(op_b), WIDTH, STEP, op_sgn));
    a_ext_start = {{WIDTH{op_sgn & op_a[WIDTH-1]}}, op_a};
    acc_start   = '0;
    if (op_mode.acc_en) acc_start = op_mode.long_en ? {acc_hi, acc_lo} : {{WIDTH{1'b0}}, acc_lo};
    last        = (k == n_q - KW'(1));
  end

  // Only the final chunk carries the multiplier's sign.
  mac_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
    .sum          (sum_q),
    .a_ext        (a_ext_q),
    .chunk        (b_sh[STEP-1:0]),
    .chunk_signed (sgn_q & last),
    .idx          (k),
    .sum_next     (sum_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      n_q       <= '0;
      b_sh      <= '0;
      a_ext_q   <= '0;
      sum_q     <= '0;
      long_q    <= 1'b0;
      sgn_q     <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      cycles    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_CALC;
            k       <= '0;
            n_q     <= n_start;
            b_sh    <= op_b;
            a_ext_q <= a_ext_start;
            sum_q   <= acc_start;
            long_q  <= op_mode.long_en;
            sgn_q   <= op_sgn;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          sum_q <= sum_next;
          b_sh  <= b_sh >> STEP;
          k     <= k + KW'(1);
          if (last) begin
            state  <= ST_DONE;
            cycles <= n_q;
            if (long_q) begin
              result_hi <= sum_next[W2-1:WIDTH];
              result_lo <= sum_next[WIDTH-1:0];
              flag_n    <= sum_next[W2-1];
              flag_z    <= (sum_next == '0);
            end else begin
              result_hi <= '0;
              result_lo <= sum_next[WIDTH-1:0];
              flag_n    <= sum_next[WIDTH-1];
              flag_z    <= (sum_next[WIDTH-1:0] == '0);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_CALC);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mac_iter.sv
// Directed bench for mac_iter: driver pushes hand-computed results into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_mac_iter;
  import mac_pkg::*;

  localparam int W  = 32;
  localparam int CW = 3;

  typedef struct packed {
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          fn;
    logic          fz;
    logic [CW-1:0] cyc;
    logic [31:0]   at;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  op_a, op_b, acc_hi, acc_lo;
  logic          acc_en, long_en, signed_en;
  logic          busy, done, flag_n, flag_z;
  logic [W-1:0]  result_hi, result_lo;
  logic [CW-1:0] cycles;
  logic [1:0]    dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  exp_t             mon_e;
  string            mon_name;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc_cnt = 0;

  mac_iter #(.WIDTH(W), .STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .acc_hi(acc_hi), .acc_lo(acc_lo), .acc_en(acc_en), .long_en(long_en),
    .signed_en(signed_en), .busy(busy), .done(done), .result_hi(result_hi),
    .result_lo(result_lo), .flag_n(flag_n), .flag_z(flag_z), .cycles(cycles),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver
  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ahi, input logic [W-1:0] alo,
                       input logic acc, input logic lng, input logic sgn, input logic expect_it,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic efn, input logic efz, input logic [CW-1:0] ecyc);
    exp_t e;
    op_a = a; op_b = b; acc_hi = ahi; acc_lo = alo;
    acc_en = acc; long_en = lng; signed_en = sgn;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_it) begin
      e.hi = ehi; e.lo = elo; e.fn = efn; e.fz = efz; e.cyc = ecyc;
      e.at = 32'(cyc_cnt) + 32'(ecyc);
      exp_q.push_back(EXP_W'(e));
      name_q.push_back(name);
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no done within 40 cycles", name);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done seen at cycle %0d with nothing expected", cyc_cnt);
      end else begin
        mon_e    = exp_t'(exp_q.pop_front());
        mon_name = name_q.pop_front();
        check({mon_name, ".result_hi"}, 64'(result_hi), 64'(mon_e.hi));
        check({mon_name, ".result_lo"}, 64'(result_lo), 64'(mon_e.lo));
        check({mon_name, ".flag_n"},    64'(flag_n),    64'(mon_e.fn));
        check({mon_name, ".flag_z"},    64'(flag_z),    64'(mon_e.fz));
        check({mon_name, ".cycles"},    64'(cycles),    64'(mon_e.cyc));
        check({mon_name, ".done_cycle"}, 64'(cyc_cnt),  64'(mon_e.at));
        check({mon_name, ".busy"},      64'(busy),      64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0;
    op_a = '0; op_b = '0; acc_hi = '0; acc_lo = '0;
    acc_en = 1'b0; long_en = 1'b0; signed_en = 1'b0;
    #1;
    check("rst.busy",      64'(busy),      64'd0);
    check("rst.done",      64'(done),      64'd0);
    check("rst.result_hi", 64'(result_hi), 64'd0);
    check("rst.result_lo", 64'(result_lo), 64'd0);
    check("rst.flags",     64'({flag_n, flag_z}), 64'd0);
    check("rst.cycles",    64'(cycles),    64'd0);
    check("rst.state",     64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    //     name     op_a          op_b          acc_hi        acc_lo  acc lng sgn exp  hi            lo            n  z  cyc
    issue("mul",    32'd3,        32'd5,        32'd0,        32'd0,  0, 0, 0, 1, 32'h0,        32'd15,       0, 0, 3'd1);
    wait_done("mul");
    issue("mla",    32'h00010000, 32'h00001234, 32'd0,        32'd7,  1, 0, 0, 1, 32'h0,        32'h12340007, 0, 0, 3'd2);
    wait_done("mla");
    issue("smull",  32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0,        32'd0,  0, 1, 1, 1, 32'h0,        32'h6,        0, 0, 3'd1);
    wait_done("smull");
    issue("umull",  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,  0, 1, 0, 1, 32'hFFFFFFFE, 32'h1,        1, 0, 3'd4);
    wait_done("umull");
    issue("smlal",  32'h80000000, 32'h7FFFFFFF, 32'd0,        32'd1,  1, 1, 1, 1, 32'hC0000000, 32'h80000001, 1, 0, 3'd4);
    wait_done("smlal");
    issue("mul0",   32'h00001234, 32'd0,        32'd0,        32'd0,  0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 3'd1);
    wait_done("mul0");
    issue("mla_wrap", 32'hFFFFFFFF, 32'd2,      32'hDEADBEEF, 32'd5,  1, 0, 1, 1, 32'h0,        32'h3,        0, 0, 3'd1);
    wait_done("mla_wrap");
    issue("umlal",  32'h12345678, 32'h00010000, 32'd1,        32'd1,  1, 1, 0, 1, 32'h00001235, 32'h56780001, 0, 0, 3'd3);
    wait_done("umlal");
    issue("smull_neg", 32'd5,     32'hFFFFFF00, 32'd0,        32'd0,  0, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFB00, 1, 0, 3'd2);
    wait_done("smull_neg");

    // second start while busy must be ignored
    issue("umull_ign", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,     32'd0,  0, 1, 0, 1, 32'hFFFFFFFE, 32'h1,        1, 0, 3'd4);
    @(negedge clk);
    op_a = 32'd2; op_b = 32'd3; long_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("umull_ign");
    @(negedge clk);
    check("hold.done_pulse", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    check("hold.result_hi", 64'(result_hi), 64'hFFFFFFFE);
    check("hold.result_lo", 64'(result_lo), 64'h1);
    check("hold.cycles",    64'(cycles),    64'd4);
    check("hold.busy",      64'(busy),      64'd0);

    // asynchronous reset in the middle of a 4-chunk operation
    issue("umull_rst", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,     32'd0,  0, 1, 0, 0, 32'h0,        32'h0,        0, 0, 3'd4);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy",      64'(busy),      64'd0);
    check("abort.done",      64'(done),      64'd0);
    check("abort.result_hi", 64'(result_hi), 64'd0);
    check("abort.result_lo", 64'(result_lo), 64'd0);
    check("abort.flags",     64'({flag_n, flag_z}), 64'd0);
    check("abort.cycles",    64'(cycles),    64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort.idle_state", 64'(dbg_state), 64'(ST_IDLE));
    check("pending_expected", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
